bmd_256_latency_drain: RTL and testbench
========================================

# bmd_256_latency_drain

Downstream consumer of the echo-latency timestamp FIFO on the TX side. Once the FIFO signals it holds a full run of 40-bit arrival timestamps, this block drains it one entry per handshake and emits a record per entry. Each record carries the raw timestamp and the modular interval from the previous one. It also keeps min/max/sum interval statistics for the run and presents them to the TX packet builder.

## Interface
- `CNT_W`, 40, timestamp width; must match the FIFO data width
- `DEPTH`, 8192, entries per run; equals FIFO depth
- `IDX_W`, `$clog2(DEPTH+1)` (14), sample-count width
- `SUM_W`, `CNT_W+IDX_W-1` (53), interval-sum width
- `clk` in 1: 250 MHz clock, the only clock
- `rst` in 1: synchronous, active-high reset
- `latency_reset_signal` in 1: synchronous run clear, same effect as `rst`
- `fifo_read_trigger` in 1: level from the FIFO stage; high means the FIFO is full and draining should start
- `fifo_counter_empty` in 1: FIFO empty flag
- `fifo_counter_value_out` in CNT_W: FIFO dout, valid 1 cycle after read enable
- `fifo_counter_read_en` out 1: single-cycle FIFO read pulse
- `rec_valid` out 1: record available
- `rec_ready` in 1: TX accepts the record
- `rec_data` out 2*CNT_W: {interval[CNT_W-1:0], timestamp[CNT_W-1:0]}
- `sample_count` out IDX_W: records accepted this run
- `min_interval` out CNT_W, `max_interval` out CNT_W, `sum_interval` out SUM_W: run statistics
- `drain_done` out 1: level, run complete

## Operation
- FSM states:
  - IDLE → READ when `fifo_read_trigger`=1.
  - READ: if `!fifo_counter_empty`, pulse `fifo_counter_read_en` and go to CAPT. If empty and trigger=0, go to DONE. If empty and trigger=1, stay in READ.
  - CAPT: register dout, compute interval, go to PRESENT.
  - PRESENT: hold `rec_valid`. On `rec_valid && rec_ready`, increment `sample_count` and update statistics. Go to DONE if the new count equals DEPTH, else go to READ.
  - DONE: hold `drain_done`=1 until `rst` or `latency_reset_signal`, then go to IDLE.
- Interval:
  - interval = (ts − prev_ts) mod 2^CNT_W, so counter wrap yields the correct positive distance.
  - The first record of a run has interval 0 and is excluded from min/max/sum.
  - prev_ts updates on handshake only.
- Statistics:
  - min initialises to all-ones and max to 0.
  - sum saturates at all-ones of SUM_W.
- Only one FIFO read is outstanding at a time. The block never asserts read enable while empty=1.
- A trigger deassertion mid-run does not stop the run. Draining continues until count=DEPTH, or until the FIFO is empty with trigger low.
- `rec_data` is stable while `rec_valid`=1 and `rec_ready`=0.

## Timing
- Reset values:
  - `fifo_counter_read_en`, `rec_valid`, `drain_done` are 0.
  - `rec_data`, `sample_count`, `max_interval`, `sum_interval` are 0.
  - `min_interval` is all-ones.
  - State is IDLE.
- `rst` and `latency_reset_signal` act in the same cycle. They drop any pending record (rec_valid deasserts the next edge) and win over a simultaneous handshake or trigger.
- Latency:
  - Trigger sampled at edge T: read enable is high in cycle T+1 and `rec_valid` in cycle T+3.
  - Minimum throughput is 1 record / 3 cycles with `rec_ready` tied high.
- Handshake completes on the edge where `rec_valid && rec_ready`. Statistics and `sample_count` are visible the cycle after.
- `drain_done` rises the cycle after the final handshake.

## Configuration
- `BMD_LATENCY_STATS_EN` defined: min/max/sum logic is built as described.
- Undefined: the statistics registers are not built. `min_interval`, `max_interval` and `sum_interval` are tied to 0. Records, `sample_count` and `drain_done` are unchanged.

## Structure
- Shared package `bmd_256_latency_pkg`: CNT_W/DEPTH defaults, FSM state enum (IDLE, READ, CAPT, PRESENT, DONE), record field offsets.
- One sub-module, `bmd_256_interval_stats`. It takes timestamp and strobe inputs and produces interval, min, max and sum outputs. It is instantiated under the macro.

## Test plan
- DEPTH=4, timestamps 100, 110, 125, 175, `rec_ready`=1: intervals 0, 10, 15, 50; min 10, max 50, sum 75; `drain_done` after the 4th record.
- Timestamps 0xFF_FFFF_FFF0 then 0x10: interval 0x20.
- `rec_ready` held low 20 cycles during PRESENT: `rec_data` is stable, exactly one read enable issued, no FIFO overread.
- Trigger dropped after 2 of 4 records with FIFO empty: DONE with `sample_count`=2. With trigger held high, READ stalls and the run resumes when empty=0.
- `latency_reset_signal` pulsed in PRESENT: next cycle `rec_valid`=0 and state IDLE; min is all-ones and count 0; a fresh trigger restarts cleanly.
- Build without `BMD_LATENCY_STATS_EN`: same records, statistics outputs read 0.

Source files
------------

// File: rtl/bmd_256_latency_pkg.sv
// bmd_256_latency_pkg: shared defaults, drain FSM states and record field offsets
package bmd_256_latency_pkg;
    localparam int CNT_W_DEF = 40;
    localparam int DEPTH_DEF = 8192;
    localparam int REC_TS_LSB = 0;
    typedef enum logic [2:0] {IDLE, READ, CAPT, PRESENT, DONE} drain_state_t;
    function automatic int rec_iv_lsb(input int cnt_w);
        return REC_TS_LSB + cnt_w;
    endfunction
endpackage

// File: rtl/bmd_256_interval_stats.sv
// bmd_256_interval_stats: modular interval register plus min/max/saturating-sum run statistics
module bmd_256_interval_stats
    import bmd_256_latency_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = CNT_W_DEF + 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capt,
    input  logic             acc,
    input  logic             first,
    input  logic [CNT_W-1:0] ts,
    input  logic [CNT_W-1:0] prev_ts,
    output logic [CNT_W-1:0] interval,
    output logic [CNT_W-1:0] min_interval,
    output logic [CNT_W-1:0] max_interval,
    output logic [SUM_W-1:0] sum_interval
);
    logic [SUM_W:0] sum_nx;
    assign sum_nx = {1'b0, sum_interval} + (SUM_W+1)'(interval);
    always_ff @(posedge clk) begin
        if (rst) begin
            interval     <= '0;
            min_interval <= '1;
            max_interval <= '0;
            sum_interval <= '0;
        end else begin
            if (capt) interval <= first ? '0 : ts - prev_ts;
            if (acc) begin
                min_interval <= interval < min_interval ? interval : min_interval;
                max_interval <= interval > max_interval ? interval : max_interval;
                sum_interval <= sum_nx[SUM_W] ? '1 : sum_nx[SUM_W-1:0];
            end
        end
    end
endmodule

// File: rtl/bmd_256_latency_drain.sv
// bmd_256_latency_drain: drains the timestamp FIFO into {interval, timestamp} records;
// define BMD_LATENCY_STATS_EN to build the min/max/sum interval statistics.
module bmd_256_latency_drain
    import bmd_256_latency_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH + 1),
    parameter int SUM_W = CNT_W + IDX_W - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               latency_reset_signal,
    input  logic               fifo_read_trigger,
    input  logic               fifo_counter_empty,
    input  logic [CNT_W-1:0]   fifo_counter_value_out,
    output logic               fifo_counter_read_en,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [2*CNT_W-1:0] rec_data,
    output logic [IDX_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   min_interval,
    output logic [CNT_W-1:0]   max_interval,
    output logic [SUM_W-1:0]   sum_interval,
    output logic               drain_done
);
    localparam int IV_LSB = rec_iv_lsb(CNT_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    drain_state_t state;
    logic [CNT_W-1:0] rec_ts, prev_ts, interval;
    logic clr, hs, first, capt;
    assign clr   = rst | latency_reset_signal;
    assign hs    = rec_valid & rec_ready;
    assign first = sample_count == '0;
    // CAPT spends its first cycle waiting for dout to follow the read pulse
    assign capt  = state == CAPT && !fifo_counter_read_en;
    assign rec_data[REC_TS_LSB +: CNT_W] = rec_ts;
    assign rec_data[IV_LSB +: CNT_W]     = interval;
    always_ff @(posedge clk) begin
        if (clr) begin
            state                <= IDLE;
            fifo_counter_read_en <= 1'b0;
            rec_valid            <= 1'b0;
            drain_done           <= 1'b0;
            rec_ts               <= '0;
            prev_ts              <= '0;
            sample_count         <= '0;
        end else begin
            fifo_counter_read_en <= 1'b0;
            case (state)
                IDLE: if (fifo_read_trigger) state <= READ;
                READ: begin
                    if (!fifo_counter_empty) begin
                        fifo_counter_read_en <= 1'b1;
                        state                <= CAPT;
                    end else if (!fifo_read_trigger) begin
                        drain_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                CAPT: begin
                    if (capt) begin
                        rec_ts    <= fifo_counter_value_out;
                        rec_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs) begin
                        rec_valid    <= 1'b0;
                        prev_ts      <= rec_ts;
                        sample_count <= sample_count + 1'b1;
                        if (sample_count == LAST) begin
                            drain_done <= 1'b1;
                            state      <= DONE;
                        end else if (!fifo_counter_empty) begin
                            // issue the next read straight from the handshake to keep 3 cycles/record
                            fifo_counter_read_en <= 1'b1;
                            state                <= CAPT;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef BMD_LATENCY_STATS_EN
    bmd_256_interval_stats #(.CNT_W(CNT_W), .SUM_W(SUM_W)) u_stats (
        .clk          (clk),
        .rst          (clr),
        .capt         (capt),
        .acc          (hs && !first),
        .first        (first),
        .ts           (fifo_counter_value_out),
        .prev_ts      (prev_ts),
        .interval     (interval),
        .min_interval (min_interval),
        .max_interval (max_interval),
        .sum_interval (sum_interval)
    );
`else
    always_ff @(posedge clk) begin
        if (clr) interval <= '0;
        else if (capt) interval <= first ? '0 : fifo_counter_value_out - prev_ts;
    end
    assign min_interval = '0;
    assign max_interval = '0;
    assign sum_interval = '0;
`endif
endmodule

// File: tb/tb_bmd_256_latency_drain.sv
// tb_bmd_256_latency_drain: FIFO model, record/statistics reference model and directed plus random runs
module tb_bmd_256_latency_drain;
    localparam int CNT_W = 40;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + IDX_W - 1;
`ifdef BMD_LATENCY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [63:0] ONES40 = 64'hFF_FFFF_FFFF;
    localparam logic [63:0] SUM_MAX = (64'd1 << SUM_W) - 64'd1;

    logic clk = 1'b0, rst = 1'b1, lrs = 1'b0, trig = 1'b0, rec_ready = 1'b0;
    logic empty, rd_en, rec_valid, drain_done;
    logic [CNT_W-1:0] dout = '0;
    logic [2*CNT_W-1:0] rec_data;
    logic [IDX_W-1:0] sample_count;
    logic [CNT_W-1:0] min_interval, max_interval;
    logic [SUM_W-1:0] sum_interval;

    logic [CNT_W-1:0] mem [64];
    int wr_ptr = 0, rd_ptr = 0, run_base = 0;
    int tests = 0, fails = 0;
    assign empty = wr_ptr == rd_ptr;

    always #5 clk = ~clk;

    bmd_256_latency_drain #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .latency_reset_signal   (lrs),
        .fifo_read_trigger      (trig),
        .fifo_counter_empty     (empty),
        .fifo_counter_value_out (dout),
        .fifo_counter_read_en   (rd_en),
        .rec_valid              (rec_valid),
        .rec_ready              (rec_ready),
        .rec_data               (rec_data),
        .sample_count           (sample_count),
        .min_interval           (min_interval),
        .max_interval           (max_interval),
        .sum_interval           (sum_interval),
        .drain_done             (drain_done)
    );

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // FIFO: dout follows a read pulse by one cycle
    always @(posedge clk) begin
        if (rd_en) begin
            chk("no_overread", 128'(wr_ptr != rd_ptr), 128'd1);
            if (wr_ptr != rd_ptr) begin
                dout   <= mem[rd_ptr % 64];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // reference model: records are the popped timestamps in order, interval is the wrapped difference
    logic armed = 1'b0;
    int m_count = 0;
    logic [63:0] m_prev = '0, m_min = ONES40, m_max = '0, m_sum = '0;
    logic [CNT_W-1:0] e_ts, e_iv;
    always @(negedge clk) begin
        e_ts = mem[(run_base + m_count) % 64];
        e_iv = m_count == 0 ? '0 : e_ts - m_prev[CNT_W-1:0];
        if (armed) begin
            chk("sample_count", 128'(sample_count), 128'(m_count));
            chk("min_interval", 128'(min_interval), STATS ? 128'(m_min) : 128'd0);
            chk("max_interval", 128'(max_interval), STATS ? 128'(m_max) : 128'd0);
            chk("sum_interval", 128'(sum_interval), STATS ? 128'(m_sum) : 128'd0);
            if (rec_valid) begin
                chk("rec_data", 128'(rec_data), 128'({e_iv, e_ts}));
                chk("reads_outstanding", 128'(rd_ptr - run_base), 128'(m_count + 1));
            end
            if (m_count == DEPTH) chk("done_at_depth", 128'(drain_done), 128'd1);
        end
        if (rst || lrs) begin
            armed   = 1'b1;
            m_count = 0;
            m_prev  = '0;
            m_min   = ONES40;
            m_max   = '0;
            m_sum   = '0;
        end else if (armed && rec_valid && rec_ready) begin
            if (m_count != 0) begin
                m_min = 64'(e_iv) < m_min ? 64'(e_iv) : m_min;
                m_max = 64'(e_iv) > m_max ? 64'(e_iv) : m_max;
                m_sum = m_sum + 64'(e_iv) > SUM_MAX ? SUM_MAX : m_sum + 64'(e_iv);
            end
            m_prev  = 64'(e_ts);
            m_count = m_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CNT_W-1:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic new_run();
        trig = 1'b0;
        lrs  = 1'b1;
        step();
        lrs      = 1'b0;
        wr_ptr   = rd_ptr;
        run_base = rd_ptr;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !rec_valid; i++) step();
        chk("wait_rec_valid", 128'(rec_valid), 128'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !drain_done; i++) step();
        chk("wait_drain_done", 128'(drain_done), 128'd1);
    endtask

    task automatic wait_count(input int n, input int budget);
        for (int i = 0; i < budget && int'(sample_count) != n; i++) step();
        chk("wait_sample_count", 128'(sample_count), 128'(n));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_rec_valid", 128'(rec_valid), 128'd0);
        chk("rst_read_en", 128'(rd_en), 128'd0);
        chk("rst_drain_done", 128'(drain_done), 128'd0);
        chk("rst_rec_data", 128'(rec_data), 128'd0);
        chk("rst_min", 128'(min_interval), STATS ? 128'(ONES40) : 128'd0);

        // run 1: fixed timestamps, ready tied high, latency and throughput pinned
        new_run();
        push(40'd100); push(40'd110); push(40'd125); push(40'd175);
        rec_ready = 1'b1;
        trig = 1'b1;
        step();
        chk("lat_rd_en_T", 128'(rd_en), 128'd0);
        step();
        chk("lat_rd_en_T1", 128'(rd_en), 128'd1);
        step();
        chk("lat_valid_T2", 128'(rec_valid), 128'd0);
        step();
        chk("lat_valid_T3", 128'(rec_valid), 128'd1);
        chk("run1_rec0", 128'(rec_data), 128'({40'd0, 40'd100}));
        repeat (3) step();
        chk("run1_rec1", 128'(rec_data), 128'({40'd10, 40'd110}));
        repeat (6) step();
        chk("run1_done_early", 128'(drain_done), 128'd0);
        step();
        chk("run1_done_T13", 128'(drain_done), 128'd1);
        chk("run1_count", 128'(sample_count), 128'd4);
        chk("run1_min", 128'(min_interval), STATS ? 128'd10 : 128'd0);
        chk("run1_max", 128'(max_interval), STATS ? 128'd50 : 128'd0);
        chk("run1_sum", 128'(sum_interval), STATS ? 128'd75 : 128'd0);

        // back-pressure: record held 20 cycles, only one read issued
        new_run();
        push(40'd200); push(40'd300); push(40'd450); push(40'd460);
        rec_ready = 1'b0;
        trig = 1'b1;
        wait_valid(20);
        repeat (20) step();
        chk("stall_data", 128'(rec_data), 128'({40'd0, 40'd200}));
        chk("stall_reads", 128'(rd_ptr - run_base), 128'd1);
        rec_ready = 1'b1;
        wait_done(40);
        chk("stall_count", 128'(sample_count), 128'd4);

        // counter wrap, then READ stalls on empty with trigger high and resumes
        new_run();
        push(40'hFF_FFFF_FFF0); push(40'h10);
        rec_ready = 1'b0;
        trig = 1'b1;
        wait_valid(20);
        chk("wrap_rec0", 128'(rec_data), 128'({40'd0, 40'hFF_FFFF_FFF0}));
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        wait_valid(20);
        chk("wrap_rec1", 128'(rec_data), 128'({40'h20, 40'h10}));
        rec_ready = 1'b1;
        repeat (10) step();
        chk("empty_stall_count", 128'(sample_count), 128'd2);
        chk("empty_stall_done", 128'(drain_done), 128'd0);
        push(40'h30); push(40'h70);
        wait_done(40);
        chk("resume_count", 128'(sample_count), 128'd4);
        chk("resume_min", 128'(min_interval), STATS ? 128'h20 : 128'd0);
        chk("resume_max", 128'(max_interval), STATS ? 128'h40 : 128'd0);
        chk("resume_sum", 128'(sum_interval), STATS ? 128'h80 : 128'd0);

        // trigger dropped with FIFO empty after two records
        new_run();
        push(40'd5); push(40'd8);
        trig = 1'b1;
        wait_count(2, 40);
        trig = 1'b0;
        wait_done(20);
        chk("drop_count", 128'(sample_count), 128'd2);
        chk("drop_max", 128'(max_interval), STATS ? 128'd3 : 128'd0);

        // run clear while a record is pending
        new_run();
        push(40'd1000); push(40'd1001); push(40'd1003); push(40'd1007);
        rec_ready = 1'b0;
        trig = 1'b1;
        wait_valid(20);
        trig = 1'b0;
        lrs = 1'b1;
        step();
        lrs = 1'b0;
        chk("clr_rec_valid", 128'(rec_valid), 128'd0);
        chk("clr_count", 128'(sample_count), 128'd0);
        chk("clr_min", 128'(min_interval), STATS ? 128'(ONES40) : 128'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("clr_idle_no_read", 128'(rd_en), 128'd0);
        end
        new_run();
        push(40'd2000); push(40'd2100); push(40'd2150); push(40'd2155);
        rec_ready = 1'b1;
        trig = 1'b1;
        wait_done(40);
        chk("restart_count", 128'(sample_count), 128'd4);

        // random timestamps with random back-pressure
        for (int r = 0; r < 10; r++) begin
            new_run();
            for (int k = 0; k < DEPTH; k++) push({8'($urandom), 32'($urandom)});
            trig = 1'b1;
            for (int i = 0; i < 300 && !drain_done; i++) begin
                rec_ready = 1'($urandom_range(0, 1));
                step();
            end
            chk("rand_done", 128'(drain_done), 128'd1);
        end

        trig = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
